bp_be_trace_replay: RTL and testbench

Trace-driven stimulus and checker node for the backend trace testbench. Walks a combinational trace ROM; each entry either drives a payload into the device under test, receives and compares a payload from it, stalls for a programmed number of cycles, or ends the test. Sits between the trace ROM and the trace ring of the BE harness: it feeds the commands the harness replays and consumes the results the harness produces. Its `done_o` / `error_o` are the test's pass/fail outputs.

---
 rtl/bp_be_trace_pkg.sv | 32 +++
 rtl/bsg_counter_set_down.sv | 24 ++
 rtl/bp_be_trace_replay.sv | 155 +++++++++++++++
 tb/tb_bp_be_trace_replay.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_trace_pkg.sv
// Shared types for the backend trace replay node.
//   bp_trace_op_e          : 4-bit trace opcode carried in the top nibble of a ROM entry
//   bp_trace_state_e       : replay FSM states
//   DECLARE_BP_TRACE_ROM_ENTRY_S(w) : declares packed ROM entry {op, payload[w-1:0]}
package bp_be_trace_pkg;

  localparam int unsigned bp_trace_op_width_lp = 4;

  typedef enum logic [3:0] {
    e_op_nop  = 4'h0,
    e_op_send = 4'h1,
    e_op_recv = 4'h2,
    e_op_wait = 4'h3,
    e_op_done = 4'h4
  } bp_trace_op_e;

  typedef enum logic [2:0] {
    eReset,
    eRun,
    eWait,
    eDone,
    eError
  } bp_trace_state_e;

endpackage

// ROM entry layout; the payload width is a module parameter, so the struct is declared per use site.
`define DECLARE_BP_TRACE_ROM_ENTRY_S(payload_width_mp) \
  typedef struct packed { \
    logic [bp_be_trace_pkg::bp_trace_op_width_lp-1:0] op; \
    logic [payload_width_mp-1:0]                      payload; \
  } bp_trace_rom_entry_s

// File: rtl/bsg_counter_set_down.sv
// Loadable down counter used for trace wait entries.
//   clk_i, reset_i : clock, synchronous active-high reset (clears count)
//   set_i, val_i   : load val_i (has priority over down_i)
//   down_i         : decrement by one
//   count_r_o      : registered count
module bsg_counter_set_down
 #(parameter int unsigned width_p = 16)
  (input  logic               clk_i,
   input  logic               reset_i,
   input  logic               set_i,
   input  logic [width_p-1:0] val_i,
   input  logic               down_i,
   output logic [width_p-1:0] count_r_o);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_r_o <= '0;
    else if (set_i)
      count_r_o <= val_i;
    else if (down_i)
      count_r_o <= count_r_o - width_p'(1);
  end

endmodule

// File: rtl/bp_be_trace_replay.sv
// Trace-driven stimulus/checker node. Walks a combinational trace ROM and, per entry,
// sends a payload to the DUT, receives and compares a payload from it, waits, or ends.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   en_i                : replay enable; low freezes all state and blocks handshakes
//   v_i, data_i, ready_o: inbound payload from the DUT (zero-latency accept)
//   v_o, data_o, yumi_i : outbound payload to the DUT
//   rom_addr_o, rom_data_i : trace ROM port, data valid in the same cycle as the address
//   done_o, error_o     : sticky pass / fail flags
module bp_be_trace_replay
  import bp_be_trace_pkg::*;
 #(parameter int unsigned trace_ring_width_p     = 32,
   parameter int unsigned trace_rom_addr_width_p = 8,
   // must not exceed trace_ring_width_p
   parameter int unsigned wait_ctr_width_p       = 16)
  (input  logic                                               clk_i,
   input  logic                                               reset_i,
   input  logic                                               en_i,

   input  logic                                               v_i,
   input  logic [trace_ring_width_p-1:0]                      data_i,
   output logic                                               ready_o,

   output logic                                               v_o,
   output logic [trace_ring_width_p-1:0]                      data_o,
   input  logic                                               yumi_i,

   output logic [trace_rom_addr_width_p-1:0]                  rom_addr_o,
   input  logic [trace_ring_width_p+bp_trace_op_width_lp-1:0] rom_data_i,

   output logic                                               done_o,
   output logic                                               error_o);

  `DECLARE_BP_TRACE_ROM_ENTRY_S(trace_ring_width_p);

  bp_trace_rom_entry_s entry;
  assign entry = rom_data_i;

  bp_trace_state_e                   state_r, state_n;
  logic [trace_rom_addr_width_p-1:0] addr_r, addr_n, addr_inc;
  logic [wait_ctr_width_p-1:0]       wait_len, ctr_val, ctr_r;
  logic                              ctr_set, ctr_down;
  logic                              v_c, ready_c;
  logic [trace_ring_width_p-1:0]     data_c;

  assign addr_inc = addr_r + trace_rom_addr_width_p'(1);
  assign wait_len = entry.payload[wait_ctr_width_p-1:0];

  // Wait counter
  bsg_counter_set_down
   #(.width_p(wait_ctr_width_p))
   wait_ctr
    (.clk_i    (clk_i),
     .reset_i  (reset_i),
     .set_i    (ctr_set),
     .val_i    (ctr_val),
     .down_i   (ctr_down),
     .count_r_o(ctr_r));

  // State and address registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eReset;
      addr_r  <= '0;
    end
    else begin
      state_r <= state_n;
      addr_r  <= addr_n;
    end
  end

  // Next state, address, counter control and handshake outputs
  always_comb begin
    state_n  = state_r;
    addr_n   = addr_r;
    ctr_set  = 1'b0;
    ctr_val  = '0;
    ctr_down = 1'b0;
    v_c      = 1'b0;
    ready_c  = 1'b0;
    data_c   = '0;

    case (state_r)
      eReset: state_n = eRun;

      eRun: begin
        // Payload follows the address, not en_i, so a withdrawn send resumes unchanged.
        if (entry.op == e_op_send)
          data_c = entry.payload;

        if (en_i) begin
          case (entry.op)
            e_op_nop: addr_n = addr_inc;

            e_op_send: begin
              v_c = 1'b1;
              if (yumi_i)
                addr_n = addr_inc;
            end

            e_op_recv: begin
              ready_c = 1'b1;
              if (v_i) begin
                if (data_i == entry.payload)
                  addr_n = addr_inc;
                else
                  state_n = eError;
              end
            end

            // The issuing cycle is the first of N+1, so the counter is loaded with N-1
            // and wait 0 advances without visiting eWait.
            e_op_wait: begin
              if (wait_len == '0)
                addr_n = addr_inc;
              else begin
                ctr_set = 1'b1;
                ctr_val = wait_len - wait_ctr_width_p'(1);
                state_n = eWait;
              end
            end

            e_op_done: state_n = eDone;

            default: state_n = eError;
          endcase
        end
      end

      eWait: begin
        if (en_i) begin
          if (ctr_r == '0) begin
            addr_n  = addr_inc;
            state_n = eRun;
          end
          else
            ctr_down = 1'b1;
        end
      end

      eDone, eError: begin
        state_n = state_r;
      end

      default: state_n = eError;
    endcase
  end

  assign v_o        = v_c;
  assign ready_o    = ready_c;
  assign data_o     = data_c;
  assign rom_addr_o = addr_r;
  assign done_o     = (state_r == eDone);
  assign error_o    = (state_r == eError);

endmodule

// File: tb/tb_bp_be_trace_replay.sv
// Bench for bp_be_trace_replay: directed trace scenarios plus random traces, checked
// against per-entry cycle costs and expected payload order.
module tb_bp_be_trace_replay;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset, en, v_i, ready_o, v_o, yumi, done_o, error_o;
  logic [W-1:0]  data_i, data_o;
  logic [AW-1:0] rom_addr_o;
  logic [W+3:0]  rom_data_i;
  logic [W+3:0]  rom [0:31];

  assign rom_data_i = rom[rom_addr_o];

  always #5 clk = ~clk;

  bp_be_trace_replay
   #(.trace_ring_width_p(W), .trace_rom_addr_width_p(AW), .wait_ctr_width_p(CW))
   dut
    (.clk_i(clk), .reset_i(reset), .en_i(en),
     .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
     .v_o(v_o), .data_o(data_o), .yumi_i(yumi),
     .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
     .done_o(done_o), .error_o(error_o));

  int tests = 0;
  int fails = 0;

  // Trace model: payload order, handshake delays and total cycle cost of the trace.
  int           n_ent;
  int           cost;
  bit           decided;
  bit           exp_err;
  logic [W-1:0] sendq[$];
  int           dly_s[$];
  logic [W-1:0] recv_pl[$];
  logic [W-1:0] recv_drv[$];
  int           dly_r[$];
  int           first_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_trace();
    for (int i = 0; i < 32; i++) rom[i] = {4'hF, W'(0)};
    n_ent = 0; cost = 0; decided = 0; exp_err = 0;
    sendq.delete(); dly_s.delete();
    recv_pl.delete(); recv_drv.delete(); dly_r.delete();
  endtask

  // Append an entry; cost accumulates until the entry that decides pass/fail.
  task automatic add(input logic [3:0] op, input logic [W-1:0] pl, input int d,
                     input logic [W-1:0] drive);
    rom[n_ent] = {op, pl};
    n_ent++;
    if (!decided) begin
      case (op)
        4'h0: cost += 1;
        4'h1: begin sendq.push_back(pl); dly_s.push_back(d); cost += 1 + d; end
        4'h2: begin
          recv_pl.push_back(pl); recv_drv.push_back(drive); dly_r.push_back(d);
          cost += 1 + d;
          if (drive !== pl) begin decided = 1; exp_err = 1; end
        end
        4'h3: cost += int'(pl) + 1;
        4'h4: begin cost += 1; decided = 1; end
        default: begin cost += 1; decided = 1; exp_err = 1; end
      endcase
    end
  endtask

  // Leaves the bench #1 into the first cycle after reset deasserts.
  task automatic do_reset();
    reset = 1'b1; en = 1'b1; yumi = 1'b0; v_i = 1'b0; data_i = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_outs", {11'(0), rom_addr_o, v_o, ready_o, data_o, done_o, error_o}, 32'h0);
    reset = 1'b0;
  endtask

  // Plays the DUT side of the trace and checks termination time and outcome.
  task automatic run_trace(input bit rand_en, input string tag);
    int k, si, ri, hold, enlow;
    bit finished, addr_chk;
    logic [AW-1:0] addr_nxt;
    k = 1; si = 0; ri = 0; hold = 0; enlow = 0; finished = 0; addr_chk = 0;
    addr_nxt = '0; first_v = 0;
    while (!finished && k <= 3000) begin
      if (done_o || error_o) finished = 1;
      else begin
        en = !(rand_en && k > 1 && $urandom_range(0, 7) == 0);
        if (!en) enlow++;
        yumi = 1'b0; v_i = 1'b0;
        #1;
        if (addr_chk) begin
          check({tag, ".addr_adv"}, 32'(rom_addr_o), 32'(addr_nxt));
          addr_chk = 0;
        end
        if (v_o) begin
          if (first_v == 0) first_v = k;
          if (si < sendq.size()) begin
            check({tag, ".data_o"}, 32'(data_o), 32'(sendq[si]));
            if (hold == dly_s[si]) begin
              yumi = 1'b1; addr_nxt = rom_addr_o + AW'(1); addr_chk = 1;
              si++; hold = 0;
            end
            else hold++;
          end
          else check({tag, ".extra_v_o"}, 32'(v_o), 32'h0);
        end
        else if (ready_o) begin
          if (ri < recv_drv.size()) begin
            if (hold == dly_r[ri]) begin
              v_i = 1'b1; data_i = recv_drv[ri];
              if (recv_drv[ri] === recv_pl[ri]) begin
                addr_nxt = rom_addr_o + AW'(1); addr_chk = 1;
              end
              ri++; hold = 0;
            end
            else hold++;
          end
          else check({tag, ".extra_ready"}, 32'(ready_o), 32'h0);
        end
        @(posedge clk); #1;
        k++;
      end
    end
    yumi = 1'b0; v_i = 1'b0; en = 1'b1;
    check({tag, ".cycles"}, 32'(k), 32'(cost + 2 + enlow));
    check({tag, ".error_o"}, 32'(error_o), 32'(exp_err));
    check({tag, ".done_o"}, 32'(done_o), 32'(!exp_err));
    if (!exp_err) check({tag, ".sends"}, 32'(si), 32'(sendq.size()));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; yumi = 1'b0; v_i = 1'b0; data_i = '0;

    // Send 0x5A held for three cycles before yumi, then done.
    new_trace();
    add(4'h1, W'(16'h005A), 3, '0);
    add(4'h4, '0, 0, '0);
    do_reset();
    run_trace(0, "send5a");
    check("send5a.first_v", 32'(first_v), 32'd2);

    // Matching receive.
    new_trace();
    add(4'h2, W'(16'h1234), 2, W'(16'h1234));
    add(4'h4, '0, 0, '0);
    do_reset();
    run_trace(0, "recv_ok");

    // Mismatching receive; ready_o must stay low afterwards.
    new_trace();
    add(4'h2, W'(16'h1234), 0, W'(16'h1235));
    add(4'h4, '0, 0, '0);
    do_reset();
    run_trace(0, "recv_bad");
    for (int i = 0; i < 3; i++) begin
      #1;
      check("recv_bad.ready_after", 32'(ready_o), 32'h0);
      check("recv_bad.error_sticky", 32'(error_o), 32'h1);
      @(posedge clk); #1;
    end

    // Wait 5 then send: v_o six cycles after the wait entry is presented.
    new_trace();
    add(4'h3, W'(5), 0, '0);
    add(4'h1, W'(16'h0007), 0, '0);
    add(4'h4, '0, 0, '0);
    do_reset();
    run_trace(0, "wait5");
    check("wait5.first_v", 32'(first_v), 32'd8);

    // Illegal opcode.
    new_trace();
    add(4'hF, '0, 0, '0);
    do_reset();
    run_trace(0, "illegal");

    // Reset in the middle of a long wait restarts from entry 0.
    new_trace();
    add(4'h3, W'(100), 0, '0);
    add(4'h1, W'(16'h0033), 1, '0);
    add(4'h4, '0, 0, '0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    check("rstwait.v_o_mid", 32'(v_o), 32'h0);
    do_reset();
    run_trace(0, "rstwait");

    // en_i dropped for 4 cycles while a send is pending.
    new_trace();
    add(4'h1, W'(16'h0ABC), 0, '0);
    add(4'h4, '0, 0, '0);
    do_reset();
    @(posedge clk); #1;
    check("enlow.v_pre", 32'(v_o), 32'h1);
    check("enlow.data_pre", 32'(data_o), 32'h0ABC);
    for (int i = 0; i < 4; i++) begin
      en = 1'b0; #1;
      check("enlow.v_o", 32'(v_o), 32'h0);
      check("enlow.addr", 32'(rom_addr_o), 32'h0);
      @(posedge clk); #1;
    end
    en = 1'b1; #1;
    check("enlow.v_resume", 32'(v_o), 32'h1);
    check("enlow.data_resume", 32'(data_o), 32'h0ABC);
    yumi = 1'b1;
    @(posedge clk); #1;
    yumi = 1'b0;
    check("enlow.addr_adv", 32'(rom_addr_o), 32'h1);
    @(posedge clk); #1;
    check("enlow.done", 32'(done_o), 32'h1);

    // Random traces with random handshake delays and enable drops.
    for (int t = 0; t < 30; t++) begin
      int nent, bad;
      logic [W-1:0] pl;
      new_trace();
      nent = int'($urandom_range(3, 12));
      bad  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nent - 1)) : -1;
      for (int i = 0; i < nent; i++) begin
        pl = W'($urandom);
        case ($urandom_range(0, 3))
          0: add(4'h0, pl, 0, '0);
          1: add(4'h1, pl, int'($urandom_range(0, 3)), '0);
          2: add(4'h2, pl, int'($urandom_range(0, 3)),
                 (i == bad) ? (pl ^ W'($urandom_range(1, 16'hFFFF))) : pl);
          default: add(4'h3, W'($urandom_range(0, 6)), 0, '0);
        endcase
      end
      add(4'h4, '0, 0, '0);
      do_reset();
      run_trace(1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
